// File: rtl/my_seq_alu.sv
// my_seq_alu: sequential unsigned ALU with add, subtract, multiply and divide.
//   Add/subtract and divide-by-zero finish one cycle after accept. Multiply
//   (shift-add) and divide (restoring) spend WIDTH cycles in CALC, one operand
//   bit per cycle, then present the result in DONE.
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       request strobe, honoured only in IDLE
//   operandA    first operand (unsigned, WIDTH bits)
//   operandB    second operand (unsigned, WIDTH bits)
//   command     00 add, 01 sub (A-B), 10 mul, 11 div (A/B)
//   busy        high from the cycle after accept through the done cycle
//   done        one-cycle result-valid pulse
//   result      2*WIDTH-bit result, held between done pulses
//   div_by_zero error flag of the most recent operation
module my_seq_alu #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     operandA,
  input  logic [WIDTH-1:0]     operandB,
  input  logic [1:0]           command,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [1:0] CMD_ADD = 2'b00;
  localparam logic [1:0] CMD_SUB = 2'b01;
  localparam logic [1:0] CMD_MUL = 2'b10;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q;
  logic [1:0]           cmd_q;
  logic [CW-1:0]        count_q;
  logic [2*WIDTH-1:0]   mcand_q;   // multiplicand, shifted left each step
  logic [2*WIDTH-1:0]   acc_q;     // partial product
  logic [WIDTH-1:0]     b_q;       // multiplier (shifted right) or divisor
  logic [WIDTH-1:0]     rem_q;     // partial remainder
  logic [WIDTH-1:0]     quo_q;     // dividend bits shift out, quotient bits shift in

  logic [2*WIDTH-1:0]   add_res_d;
  logic [2*WIDTH-1:0]   sub_res_d;
  logic [2*WIDTH-1:0]   mul_sum_d;
  logic [WIDTH:0]       rem_shift_d;
  logic [WIDTH:0]       trial_d;
  logic [WIDTH-1:0]     rem_d;
  logic [WIDTH-1:0]     quo_d;

  always_comb begin
    add_res_d   = {{WIDTH{1'b0}}, operandA} + {{WIDTH{1'b0}}, operandB};
    sub_res_d   = {{WIDTH{1'b0}}, operandA} - {{WIDTH{1'b0}}, operandB};
    mul_sum_d   = acc_q + (b_q[0] ? mcand_q : {2*WIDTH{1'b0}});
    rem_shift_d = {rem_q, quo_q[WIDTH-1]};
    trial_d     = rem_shift_d - {1'b0, b_q};
    // Partial remainder is always below the divisor, so the shifted value fits
    // in WIDTH+1 bits and trial_d's MSB is exactly the borrow (restore case).
    rem_d       = trial_d[WIDTH] ? rem_shift_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
    quo_d       = {quo_q[WIDTH-2:0], ~trial_d[WIDTH]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= 2'b00;
      count_q     <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cmd_q       <= command;
            count_q     <= '0;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            case (command)
              CMD_ADD: begin
                result  <= add_res_d;
                done    <= 1'b1;
                state_q <= DONE;
              end
              CMD_SUB: begin
                result  <= sub_res_d;
                done    <= 1'b1;
                state_q <= DONE;
              end
              CMD_MUL: begin
                mcand_q <= {{WIDTH{1'b0}}, operandA};
                b_q     <= operandB;
                acc_q   <= '0;
                state_q <= CALC;
              end
              default: begin
                if (operandB == '0) begin
                  result      <= '1;
                  div_by_zero <= 1'b1;
                  done        <= 1'b1;
                  state_q     <= DONE;
                end else begin
                  rem_q   <= '0;
                  quo_q   <= operandA;
                  b_q     <= operandB;
                  state_q <= CALC;
                end
              end
            endcase
          end
        end
        CALC: begin
          count_q <= count_q + 1'b1;
          if (cmd_q == CMD_MUL) begin
            acc_q   <= mul_sum_d;
            mcand_q <= mcand_q << 1;
            b_q     <= b_q >> 1;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
          end
          // The last step's value goes straight to result; intermediate
          // values never reach the output.
          if (count_q == CW'(WIDTH - 1)) begin
            result  <= (cmd_q == CMD_MUL) ? mul_sum_d : {rem_d, quo_d};
            done    <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_my_seq_alu.sv
// Randomised + directed self-checking bench for my_seq_alu (WIDTH=4).
module tb_my_seq_alu;
  localparam int W  = 4;
  localparam int RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  opa = '0;
  logic [W-1:0]  opb = '0;
  logic [1:0]    cmd = 2'b00;
  logic          busy;
  logic          done;
  logic [RW-1:0] result;
  logic          dbz;

  int n_checks = 0;
  int n_fail   = 0;
  logic [RW-1:0] last_res = '0;
  logic          last_dbz = 1'b0;

  my_seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .operandA(opa), .operandB(opb), .command(cmd),
    .busy(busy), .done(done), .result(result), .div_by_zero(dbz)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic from the operation definitions.
  function automatic logic [RW-1:0] model_result(input int unsigned a, input int unsigned b,
                                                 input int unsigned c);
    int unsigned v;
    case (c)
      0: v = a + b;
      1: v = a - b;                       // wraps mod 2^32, truncated below
      2: v = a * b;
      default: v = (b == 0) ? ((1 << RW) - 1) : (((a % b) << W) | (a / b));
    endcase
    return v[RW-1:0];
  endfunction

  function automatic int model_latency(input int unsigned b, input int unsigned c);
    if (c == 2 || (c == 3 && b != 0)) return W + 1;
    return 1;
  endfunction

  // Call at a negedge with the DUT idle; returns at the negedge of the cycle
  // after done, DUT idle again. noisy=1 scrambles inputs while busy.
  task automatic do_op(input int unsigned a, input int unsigned b, input int unsigned c,
                       input bit noisy);
    logic [RW-1:0] exp_r;
    int exp_lat;
    logic exp_dbz;
    bit seen;
    start = 1'b1; opa = W'(a); opb = W'(b); cmd = 2'(c);
    exp_r   = model_result(a, b, c);
    exp_lat = model_latency(b, c);
    exp_dbz = (c == 3 && b == 0);
    @(posedge clk);
    seen = 0;
    for (int k = 1; k <= exp_lat + 3 && !seen; k++) begin
      @(negedge clk);
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        opa = W'($urandom); opb = W'($urandom); cmd = 2'($urandom);
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1;
        check_eq("latency", 64'(k), 64'(exp_lat));
        check_eq("result", 64'(result), 64'(exp_r));
        check_eq("div_by_zero", 64'(dbz), 64'(exp_dbz));
        check_eq("busy_at_done", 64'(busy), 64'd1);
      end else begin
        check_eq("busy", 64'(busy), 64'd1);
        check_eq("result_hold", 64'(result), 64'(last_res));
      end
    end
    check_eq("done_seen", 64'(seen), 64'd1);
    @(negedge clk);
    start = 1'b0;
    check_eq("idle_busy", 64'(busy), 64'd0);
    check_eq("idle_done", 64'(done), 64'd0);
    check_eq("result_after", 64'(result), 64'(exp_r));
    $display("op a=%0d b=%0d cmd=%0d -> result=0x%0h dbz=%0b (exp 0x%0h)",
             a, b, c, result, dbz, exp_r);
    last_res = exp_r;
    last_dbz = exp_dbz;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_result", 64'(result), 64'd0);
    check_eq("rst_dbz", 64'(dbz), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(15, 15, 0, 0);   // 0x1E
    do_op(3, 5, 1, 0);     // 0xFE
    do_op(15, 15, 2, 0);   // 0xE1
    do_op(0, 9, 2, 0);     // 0x00
    do_op(13, 4, 3, 0);    // 0x13
    do_op(9, 0, 3, 0);     // 0xFF, dbz
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("dbz_hold", 64'(dbz), 64'(last_dbz));
      check_eq("idle_result_hold", 64'(result), 64'(last_res));
    end
    do_op(7, 7, 2, 1);     // 0x31 with scrambled inputs, dbz cleared

    // Reset in the middle of a divide.
    start = 1'b1; opa = 4'd13; opb = 4'd4; cmd = 2'd3;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_busy", 64'(busy), 64'd0);
    check_eq("async_done", 64'(done), 64'd0);
    check_eq("async_result", 64'(result), 64'd0);
    check_eq("async_dbz", 64'(dbz), 64'd0);
    start = 1'b1;          // must be ignored while in reset
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("no_done_in_reset", 64'(done), 64'd0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset_idle", 64'(busy), 64'd0);
    last_res = '0;
    last_dbz = 1'b0;
    do_op(1, 2, 0, 0);     // 0x03

    for (int i = 0; i < 150; i++) begin
      do_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
            1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
